dut_uart_rx: RTL and testbench
==============================

Name: dut_uart_rx

Overview:
UART receiver that listens on the DUT serial output line, so the DUT's FIR result stream can be checked inside the fabric during fault-injection campaigns. The receiver oversamples the line and rejects glitches on the start bit. Each good 8N1 byte is delivered on a valid/ready interface. Framing errors and overruns are flagged so that injected upsets corrupting the DUT UART are visible. The block sits in the top level next to the DUT instance, on the 100 MHz system clock.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency
BAUD, 115200, line rate
OVERSAMPLE, 16, samples per bit; must be even and at least 8
DIV (localparam), round(CLK_FREQ_HZ/(BAUD*OVERSAMPLE)), clocks per sample tick; minimum 1

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rxd_i  in  1  serial input (DUT S_OUT), asynchronous to clk, idle high
data_o  out  8  received byte
valid_o  out  1  data_o holds an unconsumed byte
ready_i  in  1  consumer accepts; handshake occurs when valid_o and ready_i are both high
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
overrun_o  out  1  sticky: a byte was dropped because valid_o was still pending
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values: data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. Synchronizer flops reset to 1. FSM resets to IDLE. Tick and sample counters reset to 0.
- rxd_i passes through a 2-flop synchronizer (rxs), giving 2 cycles of latency.
- Tick generator: counts 0..DIV-1 and asserts tick when the count is DIV-1. It is held at 0 in IDLE and restarts on start detection.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs==0 -> START, sample counter cleared.
  - START: after OVERSAMPLE/2 ticks, sample rxs. If rxs==1 it is a false start -> IDLE with no flags. If rxs==0 -> DATA, sample counter cleared.
  - DATA: every OVERSAMPLE ticks, sample one bit, LSB first, into the shift register. After bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rxs. If rxs==1 -> IDLE and deliver the byte. If rxs==0, pulse frame_err_o for one cycle, discard the byte and go to BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. This prevents a held-low line from producing back-to-back false frames.
- Stop-bit timing: the FSM returns to IDLE at mid stop bit, so a start bit directly after the stop bit is caught.
- Delivery: data_o and valid_o update on the clock edge after the stop-bit sample. valid_o stays high until the handshake.
- Simultaneous delivery and handshake: the new byte is loaded, valid_o stays 1, and no overrun is flagged.
- Delivery with valid_o=1 and ready_i=0: the old byte is kept, the new byte is dropped and overrun_o is set.
- overrun_o is cleared on the next handshake; a delivery in that same cycle takes priority and leaves overrun_o set.
- rstn asserted mid-frame: everything returns to reset values immediately. After release, the FSM resumes in IDLE, and a line that is still low starts a new frame.

Optional Feature:
Macro: DUT_RX_PARITY_EN. When defined, the frame is 8E1:
- A PARITY state is added between DATA and STOP.
- A port parity_err_o (out, 1) is added: a one-cycle pulse when the received parity bit does not equal the XOR of the data bits.
- A byte with bad parity is discarded. Any stop-bit check still applies.
When not defined, the frame is 8N1 and neither the PARITY state nor the port exists.

Decomposition:
- Package dut_uart_pkg holds:
  - the state enum,
  - DATA_BITS=8,
  - the function computing DIV from the parameters,
  - the constant IDLE_LEVEL=1'b1.
- One sub-module, dut_uart_rx_tick, contains the tick counter with DIV, clear and tick ports.

Test Plan:
All tests use CLK_FREQ_HZ=100000000, BAUD=781250, OVERSAMPLE=16, which gives DIV=8 and a bit period of 128 clk.
1. Send 0xA5 in 8N1 with ready_i=1 -> valid_o high for 1 cycle with data_o=0xA5, about 1218 clk after the start edge; no flags.
2. Pulse rxd_i low for 40 clk -> no valid_o, no frame_err_o; busy_o returns to 0.
3. Send 0x3C with the stop bit held low, then hold the line low for 500 clk -> frame_err_o pulses once, no valid_o; busy_o stays high until the line goes high.
4. ready_i=0; send 0x11 then 0x22 back-to-back -> data_o=0x11, overrun_o=1. Raise ready_i -> handshake, overrun_o clears.
5. Assert rstn low mid-DATA of 0x55, release, then send 0x96 -> only 0x96 is delivered; outputs are at reset values during reset.
6. With DUT_RX_PARITY_EN defined: send 0x07 with the wrong parity bit -> parity_err_o pulses, no valid_o; send it with the correct parity bit (1) -> valid_o with data_o=0x07.

Source files
------------

// File: rtl/dut_uart_pkg.sv
// Shared constants, state encoding and divider helper for the dut_uart_rx receiver.
// Optional 8E1 framing is enabled with DUT_RX_PARITY_EN.
package dut_uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
`ifdef DUT_RX_PARITY_EN
  localparam state_t S_PARITY = 3'd3;
`endif
  localparam state_t S_STOP   = 3'd4;
  localparam state_t S_BREAK  = 3'd5;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    int d;
    den = baud * os;
    d   = (clk_hz + den / 2) / den;
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/dut_uart_rx_tick.sv
// Oversample tick generator: counts 0..DIV-1, tick on DIV-1, held at 0 while clr_i.
module dut_uart_rx_tick #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dut_uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 when DUT_RX_PARITY_EN is defined) with
// start-glitch rejection, framing/overrun flags and a valid/ready byte output.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs low
// START  | half-bit wait, confirm start bit still low
// DATA   | sample 8 data bits LSB first, one per bit period
// PARITY | sample even-parity bit (DUT_RX_PARITY_EN only)
// STOP   | sample stop bit at mid-bit, deliver or flag framing error
// BREAK  | line held low after a bad stop bit, wait for it to go high
module dut_uart_rx
  import dut_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
`ifdef DUT_RX_PARITY_EN
  ,
  output logic                 parity_err_o
`endif
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 tick;
  logic                 tick_clr;
  logic                 deliver;
  logic                 hs;

  state_t               state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef DUT_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  assign rxs      = sync_q[1];
  assign tick_clr = (state_q == S_IDLE);
  assign hs       = valid_q & ready_i;

  dut_uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;
`ifdef DUT_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        samp_d = '0;
        bit_d  = '0;
`ifdef DUT_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          if (samp_q == SAMP_HALF) begin
            samp_d  = '0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
`ifdef DUT_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
`ifdef DUT_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            state_d = S_STOP;
            if (rxs != ^shift_q) begin
              par_bad_d = 1'b1;
              perr_d    = 1'b1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            if (rxs) begin
              // Leave at mid stop bit so a following start edge is not missed.
              state_d = S_IDLE;
`ifdef DUT_RX_PARITY_EN
              deliver = !par_bad_q;
`else
              deliver = 1'b1;
`endif
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A delivery in a handshake cycle replaces the byte and keeps any pending overrun.
    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= {2{IDLE_LEVEL}};
      state_q <= S_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DUT_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef DUT_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != S_IDLE);
`ifdef DUT_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_dut_uart_rx.sv
// Scoreboard bench for dut_uart_rx at DIV=8 (128 clk per bit); parity cases run
// only when DUT_RX_PARITY_EN is defined.
module tb_dut_uart_rx;

  localparam int BIT_CLK = 128;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rxd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
`ifdef DUT_RX_PARITY_EN
  logic       parity_err_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int last_valid_cyc = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dut_uart_rx #(
    .CLK_FREQ_HZ(100000000),
    .BAUD       (781250),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rxd_i       (rxd_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
`ifdef DUT_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  // Monitor: pops the expected byte on every handshake and counts flag pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (valid_o && ready_i) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %02h, required none", data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin
            n_err++;
            $display("FAIL byte_data: got %02h, required %02h", data_o, e);
          end
        end
        last_valid_cyc = cyc;
      end
      if (frame_err_o) ferr_cnt++;
`ifdef DUT_RX_PARITY_EN
      if (parity_err_o) perr_cnt++;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd_i = v;
    wait_cyc(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit use_par, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (use_par) send_bit(par);
    send_bit(stop);
  endtask

  initial begin
    int t0;
    int f0;
    rstn    = 1'b0;
    rxd_i   = 1'b1;
    ready_i = 1'b1;
    wait_cyc(5);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rstn = 1'b1;
    wait_cyc(20);

    // 1: basic byte and latency from start edge
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    wait_cyc(20);
    check("t1_latency_ok", ((last_valid_cyc - t0) >= 1214) && ((last_valid_cyc - t0) <= 1224), 1'b1);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovr", overrun_o, 1'b0);

    // 2: start-bit glitch
    rxd_i = 1'b0;
    wait_cyc(30);
    check("t2_busy_during", busy_o, 1'b1);
    wait_cyc(10);
    rxd_i = 1'b1;
    wait_cyc(200);
    check("t2_busy_after", busy_o, 1'b0);
    check("t2_ferr", ferr_cnt, 0);

    // 3: bad stop bit, line held low
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    wait_cyc(500);
    check("t3_ferr_once", ferr_cnt - f0, 1);
    check("t3_busy_low", busy_o, 1'b1);
    rxd_i = 1'b1;
    wait_cyc(5);
    check("t3_busy_released", busy_o, 1'b0);
    wait_cyc(100);

    // 4: overrun
    ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b0);
    wait_cyc(20);
    check("t4_data_kept", data_o, 8'h11);
    check("t4_valid", valid_o, 1'b1);
    check("t4_ovr_set", overrun_o, 1'b1);
    ready_i = 1'b1;
    wait_cyc(3);
    check("t4_ovr_clear", overrun_o, 1'b0);
    check("t4_valid_clear", valid_o, 1'b0);
    wait_cyc(50);

    // 5: reset mid-DATA
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_cyc(40);
    rstn = 1'b0;
    #2;
    check("t5_rst_data", data_o, 8'h00);
    check("t5_rst_valid", valid_o, 1'b0);
    check("t5_rst_busy", busy_o, 1'b0);
    check("t5_rst_ovr", overrun_o, 1'b0);
    check("t5_rst_ferr", frame_err_o, 1'b0);
    wait_cyc(10);
    rxd_i = 1'b1;
    rstn  = 1'b1;
    wait_cyc(200);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 0, 1'b0);
    wait_cyc(20);
    check("t5_busy_idle", busy_o, 1'b0);

`ifdef DUT_RX_PARITY_EN
    // 6: parity
    send_frame(8'h07, 1'b1, 1, 1'b0);
    wait_cyc(20);
    check("t6_perr_once", perr_cnt, 1);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1, 1'b1);
    wait_cyc(20);
    check("t6_perr_none", perr_cnt, 1);
`endif

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_cyc(1);
    check("drain_queue_empty", exp_q.size(), 0);
    check("final_ferr_total", ferr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
